nfa_match_sched: RTL and testbench
==================================

# nfa_match_sched

Per-packet sequencer and match-report arbiter for a bank of NFA regex engines. Pulses the engines' start-of-data reset, gates their enable while payload bytes stream in, and drains the engine pipeline after the last byte. It then serializes every engine whose sticky match output fired onto a single valid/ready report channel toward the host match FIFO. Sits between the byte/char-decoder front end and the engine array.

## Interface
- NUM_ENGINES, 8, number of engine `out` lines collected (1..64)
- DRAIN_CYCLES, 2, enabled cycles after the last byte so final-state flops settle (≥1)
- LEN_W, 16, byte-offset counter width
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- pkt_start  in  1  pulse: new packet begins; honoured only in IDLE
- byte_valid  in  1  payload byte present on char decoder this cycle
- pkt_end  in  1  qualifies byte_valid: this is the last byte
- byte_ready  out  1  byte accepted when byte_valid&byte_ready
- eng_out  in  NUM_ENGINES  sticky match outputs of engines
- eng_sod  out  1  engine start-of-data/reset
- eng_en  out  1  engine enable
- dec_blank  out  1  forces all char-decoder lines low
- rpt_valid  out  1  report valid
- rpt_ready  in  1  downstream accept
- rpt_id  out  $clog2(NUM_ENGINES)  matching engine index
- rpt_offset  out  LEN_W  bytes accepted when match first seen
- rpt_last  out  1  final report of this packet
- pkt_done  out  1  one-cycle pulse, packet fully retired
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, START, SCAN, DRAIN, REPORT.
- IDLE: pkt_start → START. All other inputs are ignored.
- START: eng_sod=1 for exactly one cycle; pending vector, offsets and byte counter are cleared. Next state SCAN.
- SCAN: byte_ready=1; eng_en=byte_valid. Each accepted byte increments byte_cnt, saturating at 2^LEN_W−1. An accepted byte with pkt_end → DRAIN.
- DRAIN: eng_en=1, dec_blank=1 for DRAIN_CYCLES cycles. Then → REPORT if any pending bit is set, else → IDLE.
- Pending capture runs in SCAN and DRAIN: pending[i] |= eng_out[i].
- REPORT: the lowest-index pending engine is presented with rpt_valid=1. rpt_last=1 when it is the only remaining pending bit. On rpt_valid&rpt_ready its bit clears. After the last accept → IDLE.
- Reports within a packet are emitted in ascending index order. Each engine is reported at most once per packet.
- pkt_done pulses in the first IDLE cycle after DRAIN (no matches) or after the final report is accepted.
- busy = (state ≠ IDLE).
- rpt_valid, once asserted, holds with stable rpt_id/rpt_offset/rpt_last until accepted.

## Timing
- Reset values while rst is high:
  - eng_sod=1 (combinational OR with rst), so engines are held in reset together with this block.
  - All other outputs 0; state IDLE; pending, offsets and counter 0.
- pkt_start at cycle t → eng_sod high at t+1 → byte_ready high from t+2.
- Last byte accepted at s → DRAIN occupies s+1..s+DRAIN_CYCLES → first rpt_valid at s+DRAIN_CYCLES+1.
- With rpt_ready held at 1, one report is issued per cycle.
- pkt_start while busy is dropped; no queueing.
- eng_out rising in the same cycle the byte counter increments captures the pre-increment count.
- rst asserted mid-packet aborts it: no partial reports and no pkt_done.

## Configuration
- NFA_SCHED_OFFSET_EN:
  - Defined: a per-engine LEN_W offset register is loaded on each pending bit's 0→1 transition with the current byte_cnt, and drives rpt_offset.
  - Undefined: offset registers are not built; rpt_offset ties to 0; the port remains.

## Structure
- Package nfa_sched_pkg holds:
  - FSM state enum
  - DRAIN_CYCLES default
  - id-width function clog2 with minimum 1
- Sub-module nfa_prio_pick: combinational lowest-set-bit finder over the pending vector. Outputs index, any, and onehot (onehot is used for clearing).

## Test plan
- Reset mid-SCAN (NUM_ENGINES=8): rst pulse → eng_sod=1 during rst, busy=0, rpt_valid=0, no pkt_done afterward.
- No match: pkt_start, 5 bytes, last with pkt_end, eng_out=0 → after 2 drain cycles, pkt_done pulses once; rpt_valid never rises.
- Two matches: eng_out[5] rises after byte 3, eng_out[1] after byte 7 of 10 → reports id=1 (offset 7, last=0), then id=5 (offset 3, last=1).
- Backpressure: rpt_ready=0 for 4 cycles with a report pending → rpt_id/rpt_offset/rpt_last stable; accepted on the first rpt_ready=1.
- pkt_start asserted during REPORT → ignored; the next pkt_start after pkt_done produces eng_sod one cycle later.
- Saturation, with LEN_W=4 and macro defined: 20 bytes, then match → rpt_offset=15.

Source files
------------

// File: rtl/nfa_sched_pkg.sv
// Shared types and helpers for the NFA match scheduler.
package nfa_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SCAN,
    ST_DRAIN,
    ST_REPORT
  } state_e;

  localparam int DRAIN_CYCLES_DEF = 2;

  // Index width that never collapses to zero bits for a single engine.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nfa_match_sched_prio.sv
// nfa_prio_pick: combinational lowest-set-bit finder over the pending vector.
module nfa_prio_pick
  import nfa_sched_pkg::*;
#(
  parameter  int N    = 8,
  localparam int ID_W = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] idx,
  output logic            any,
  output logic [N-1:0]    onehot
);

  // Descending scan so the lowest set bit wins the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

  assign any    = |req;
  assign onehot = req & (~req + N'(1));

endmodule

// File: rtl/nfa_match_sched.sv
// Per-packet sequencer and match-report arbiter for a bank of NFA engines.
// Define NFA_SCHED_OFFSET_EN to build per-engine match-offset registers.
module nfa_match_sched
  import nfa_sched_pkg::*;
#(
  parameter  int NUM_ENGINES  = 8,
  parameter  int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter  int LEN_W        = 16,
  localparam int ID_W         = clog2_min1(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pkt_start,
  input  logic                   byte_valid,
  input  logic                   pkt_end,
  output logic                   byte_ready,
  input  logic [NUM_ENGINES-1:0] eng_out,
  output logic                   eng_sod,
  output logic                   eng_en,
  output logic                   dec_blank,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_W-1:0]        rpt_id,
  output logic [LEN_W-1:0]       rpt_offset,
  output logic                   rpt_last,
  output logic                   pkt_done,
  output logic                   busy
);

  localparam int DC_W = clog2_min1(DRAIN_CYCLES);

  state_e                 state_q, state_d;
  logic [NUM_ENGINES-1:0] pending_q, pending_d;
  logic [LEN_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [DC_W-1:0]        drain_cnt_q, drain_cnt_d;
  logic                   pkt_done_q, pkt_done_d;

  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;
  logic [NUM_ENGINES-1:0] pick_onehot;

  nfa_prio_pick #(.N(NUM_ENGINES)) u_pick (
    .req    (pending_q),
    .idx    (pick_idx),
    .any    (pick_any),
    .onehot (pick_onehot)
  );

  assign rpt_valid = (state_q == ST_REPORT) && pick_any;
  assign rpt_id    = rpt_valid ? pick_idx : '0;
  assign rpt_last  = rpt_valid && ((pending_q & ~pick_onehot) == '0);
  assign eng_sod   = rst || (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign pkt_done  = pkt_done_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    byte_cnt_d  = byte_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pkt_done_d  = 1'b0;
    byte_ready  = 1'b0;
    eng_en      = 1'b0;
    dec_blank   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_start) state_d = ST_START;
      end
      ST_START: begin
        pending_d  = '0;
        byte_cnt_d = '0;
        state_d    = ST_SCAN;
      end
      ST_SCAN: begin
        byte_ready = 1'b1;
        eng_en     = byte_valid;
        pending_d  = pending_q | eng_out;
        if (byte_valid) begin
          if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + LEN_W'(1);
          if (pkt_end) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        eng_en    = 1'b1;
        dec_blank = 1'b1;
        pending_d = pending_q | eng_out;
        // Decide on pending_d so a match landing in the last drain cycle counts.
        if (drain_cnt_q == DC_W'(DRAIN_CYCLES - 1)) begin
          state_d    = (|pending_d) ? ST_REPORT : ST_IDLE;
          pkt_done_d = ~|pending_d;
        end else begin
          drain_cnt_d = drain_cnt_q + DC_W'(1);
        end
      end
      ST_REPORT: begin
        if (rpt_ready) begin
          pending_d = pending_q & ~pick_onehot;
          if (rpt_last) begin
            state_d    = ST_IDLE;
            pkt_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      byte_cnt_q  <= '0;
      drain_cnt_q <= '0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      byte_cnt_q  <= byte_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

`ifdef NFA_SCHED_OFFSET_EN
  logic [NUM_ENGINES-1:0][LEN_W-1:0] offset_q, offset_d;

  // Offset latches the pre-increment count on the first sighting of a match.
  always_comb begin
    offset_d = offset_q;
    if (state_q == ST_START) offset_d = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (pending_d[i] && !pending_q[i]) offset_d[i] = byte_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) offset_q <= '0;
    else     offset_q <= offset_d;
  end

  assign rpt_offset = rpt_valid ? offset_q[pick_idx] : '0;
`else
  logic unused_byte_cnt;
  assign unused_byte_cnt = ^byte_cnt_q;
  assign rpt_offset      = '0;
`endif

endmodule

// File: tb/tb_nfa_match_sched.sv
// Directed self-checking bench for nfa_match_sched (8 engines, 2 drain cycles, 4-bit offsets).
module tb_nfa_match_sched;

  logic       clk, rst;
  logic       pkt_start, byte_valid, pkt_end, byte_ready;
  logic [7:0] eng_out;
  logic       eng_sod, eng_en, dec_blank;
  logic       rpt_valid, rpt_ready, rpt_last, pkt_done, busy;
  logic [2:0] rpt_id;
  logic [3:0] rpt_offset;

  int errors = 0;
  int checks = 0;

`ifdef NFA_SCHED_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif

  function automatic logic [3:0] exp_ofs(input logic [3:0] v);
    return OFS_EN ? v : 4'd0;
  endfunction

  nfa_match_sched #(.NUM_ENGINES(8), .DRAIN_CYCLES(2), .LEN_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_start  (pkt_start),
    .byte_valid (byte_valid),
    .pkt_end    (pkt_end),
    .byte_ready (byte_ready),
    .eng_out    (eng_out),
    .eng_sod    (eng_sod),
    .eng_en     (eng_en),
    .dec_blank  (dec_blank),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_id     (rpt_id),
    .rpt_offset (rpt_offset),
    .rpt_last   (rpt_last),
    .pkt_done   (pkt_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Begins at a negedge with pkt_start high; ends at the first SCAN negedge.
  task automatic open_pkt();
    pkt_start = 1'b1;
    tick();
    pkt_start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({eng_sod, busy, rpt_valid, pkt_done, byte_ready, eng_en, dec_blank} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 1000000",
               {eng_sod, busy, rpt_valid, pkt_done, byte_ready, eng_en, dec_blank});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({eng_sod, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: got sod/busy=%b expected 00", {eng_sod, busy});
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    open_pkt();
    byte_valid = 1'b1;
    eng_out = 8'h04;
    tick();
    tick();
    rst = 1'b1;
    byte_valid = 1'b0;
    eng_out = 8'h00;
    #1;
    checks++;
    if ({eng_sod, busy, rpt_valid} !== 3'b100) begin
      errors++;
      $display("FAIL abort_in_reset: got sod/busy/valid=%b expected 100", {eng_sod, busy, rpt_valid});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pkt_done || rpt_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_no_match();
    int vseen = 0;
    pkt_start = 1'b1;
    tick();
    checks++;
    if ({eng_sod, busy, byte_ready} !== 3'b110) begin
      errors++;
      $display("FAIL start_sod: got sod/busy/ready=%b expected 110", {eng_sod, busy, byte_ready});
    end
    pkt_start = 1'b0;
    tick();
    checks++;
    if ({byte_ready, eng_sod, eng_en} !== 3'b100) begin
      errors++;
      $display("FAIL scan_entry: got ready/sod/en=%b expected 100", {byte_ready, eng_sod, eng_en});
    end
    for (int k = 1; k <= 5; k++) begin
      byte_valid = 1'b1;
      pkt_end = (k == 5);
      #1;
      if (k == 1) begin
        checks++;
        if (eng_en !== 1'b1) begin
          errors++;
          $display("FAIL scan_en: got %b expected 1", eng_en);
        end
      end
      tick();
    end
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    checks++;
    if ({dec_blank, eng_en, byte_ready, rpt_valid} !== 4'b1100) begin
      errors++;
      $display("FAIL drain1: got blank/en/ready/valid=%b expected 1100",
               {dec_blank, eng_en, byte_ready, rpt_valid});
    end
    tick();
    checks++;
    if ({dec_blank, pkt_done, rpt_valid} !== 3'b100) begin
      errors++;
      $display("FAIL drain2: got blank/done/valid=%b expected 100", {dec_blank, pkt_done, rpt_valid});
    end
    tick();
    checks++;
    if ({pkt_done, busy, rpt_valid} !== 3'b100) begin
      errors++;
      $display("FAIL nomatch_done: got done/busy/valid=%b expected 100", {pkt_done, busy, rpt_valid});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pkt_done || rpt_valid) vseen++;
    end
    checks++;
    if (vseen !== 0) begin
      errors++;
      $display("FAIL nomatch_single_pulse: got %0d extra cycles expected 0", vseen);
    end
  endtask

  task automatic test_two_matches();
    open_pkt();
    for (int k = 1; k <= 10; k++) begin
      byte_valid = 1'b1;
      pkt_end = (k == 10);
      if (k == 4) eng_out[5] = 1'b1;
      if (k == 8) eng_out[1] = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    checks++;
    if (rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_drain1_valid: got %b expected 0", rpt_valid);
    end
    tick();
    checks++;
    if (rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_drain2_valid: got %b expected 0", rpt_valid);
    end
    tick();
    checks++;
    if ({rpt_valid, rpt_id, rpt_offset, rpt_last} !== {1'b1, 3'd1, exp_ofs(4'd7), 1'b0}) begin
      errors++;
      $display("FAIL two_first: got v/id/ofs/last=%b/%0d/%0d/%b expected 1/1/%0d/0",
               rpt_valid, rpt_id, rpt_offset, rpt_last, exp_ofs(4'd7));
    end
    rpt_ready = 1'b1;
    tick();
    checks++;
    if ({rpt_valid, rpt_id, rpt_offset, rpt_last} !== {1'b1, 3'd5, exp_ofs(4'd3), 1'b1}) begin
      errors++;
      $display("FAIL two_second: got v/id/ofs/last=%b/%0d/%0d/%b expected 1/5/%0d/1",
               rpt_valid, rpt_id, rpt_offset, rpt_last, exp_ofs(4'd3));
    end
    tick();
    checks++;
    if ({rpt_valid, pkt_done, busy} !== 3'b010) begin
      errors++;
      $display("FAIL two_done: got valid/done/busy=%b expected 010", {rpt_valid, pkt_done, busy});
    end
    rpt_ready = 1'b0;
    eng_out = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    open_pkt();
    for (int k = 1; k <= 2; k++) begin
      byte_valid = 1'b1;
      pkt_end = (k == 2);
      if (k == 1) eng_out[3] = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    eng_out[6] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rpt_valid, rpt_id, rpt_offset, rpt_last} !== {1'b1, 3'd3, 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v/id/ofs/last=%b/%0d/%0d/%b expected 1/3/0/0",
                 i, rpt_valid, rpt_id, rpt_offset, rpt_last);
      end
      if (i < 4) tick();
    end
    rpt_ready = 1'b1;
    tick();
    checks++;
    if ({rpt_valid, rpt_id, rpt_offset, rpt_last} !== {1'b1, 3'd6, exp_ofs(4'd2), 1'b1}) begin
      errors++;
      $display("FAIL bp_next: got v/id/ofs/last=%b/%0d/%0d/%b expected 1/6/%0d/1",
               rpt_valid, rpt_id, rpt_offset, rpt_last, exp_ofs(4'd2));
    end
    tick();
    checks++;
    if ({rpt_valid, pkt_done} !== 2'b01) begin
      errors++;
      $display("FAIL bp_done: got valid/done=%b expected 01", {rpt_valid, pkt_done});
    end
    rpt_ready = 1'b0;
    eng_out = 8'h00;
    tick();
  endtask

  task automatic test_start_while_busy();
    open_pkt();
    byte_valid = 1'b1;
    pkt_end = 1'b1;
    eng_out[0] = 1'b1;
    tick();
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    tick();
    tick();
    pkt_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({busy, rpt_valid, rpt_id, rpt_last, eng_sod} !== {1'b1, 1'b1, 3'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL busy_start_%0d: got busy/v/id/last/sod=%b/%b/%0d/%b/%b expected 1/1/0/1/0",
                 i, busy, rpt_valid, rpt_id, rpt_last, eng_sod);
      end
    end
    pkt_start = 1'b0;
    rpt_ready = 1'b1;
    tick();
    checks++;
    if ({pkt_done, busy, eng_sod} !== 3'b100) begin
      errors++;
      $display("FAIL busy_start_dropped: got done/busy/sod=%b expected 100", {pkt_done, busy, eng_sod});
    end
    rpt_ready = 1'b0;
    eng_out = 8'h00;
    pkt_start = 1'b1;
    tick();
    checks++;
    if ({eng_sod, busy} !== 2'b11) begin
      errors++;
      $display("FAIL restart_sod: got sod/busy=%b expected 11", {eng_sod, busy});
    end
    pkt_start = 1'b0;
    tick();
    byte_valid = 1'b1;
    pkt_end = 1'b1;
    tick();
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    tick();
    tick();
    checks++;
    if ({pkt_done, rpt_valid} !== 2'b10) begin
      errors++;
      $display("FAIL restart_done: got done/valid=%b expected 10", {pkt_done, rpt_valid});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] ids [4];
    ids[0] = 3'd0; ids[1] = 3'd2; ids[2] = 3'd5; ids[3] = 3'd7;
    open_pkt();
    byte_valid = 1'b1;
    pkt_end = 1'b1;
    eng_out = 8'hA5;
    rpt_ready = 1'b1;
    tick();
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    tick();
    tick();
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({rpt_valid, rpt_id, rpt_last} !== {1'b1, ids[j], (j == 3)}) begin
        errors++;
        $display("FAIL b2b_%0d: got v/id/last=%b/%0d/%b expected 1/%0d/%b",
                 j, rpt_valid, rpt_id, rpt_last, ids[j], (j == 3));
      end
      tick();
    end
    checks++;
    if ({rpt_valid, pkt_done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: got valid/done=%b expected 01", {rpt_valid, pkt_done});
    end
    rpt_ready = 1'b0;
    eng_out = 8'h00;
    tick();
  endtask

  task automatic test_saturation();
    open_pkt();
    for (int k = 1; k <= 20; k++) begin
      byte_valid = 1'b1;
      pkt_end = (k == 20);
      tick();
    end
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    eng_out[7] = 1'b1;
    tick();
    tick();
    checks++;
    if ({rpt_valid, rpt_id, rpt_offset, rpt_last} !== {1'b1, 3'd7, exp_ofs(4'd15), 1'b1}) begin
      errors++;
      $display("FAIL sat_offset: got v/id/ofs/last=%b/%0d/%0d/%b expected 1/7/%0d/1",
               rpt_valid, rpt_id, rpt_offset, rpt_last, exp_ofs(4'd15));
    end
    rpt_ready = 1'b1;
    tick();
    checks++;
    if ({rpt_valid, pkt_done} !== 2'b01) begin
      errors++;
      $display("FAIL sat_done: got valid/done=%b expected 01", {rpt_valid, pkt_done});
    end
    rpt_ready = 1'b0;
    eng_out = 8'h00;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    pkt_start = 1'b0;
    byte_valid = 1'b0;
    pkt_end = 1'b0;
    eng_out = 8'h00;
    rpt_ready = 1'b0;
    test_reset();
    test_reset_mid_scan();
    test_no_match();
    test_two_matches();
    test_backpressure();
    test_start_while_busy();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
